// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared constants for the 16-bit carry-select adder.
//   WIDTH           : datapath width of the adder (16)
//   BLOCK_W_DEFAULT : default carry-select block width
//   NUM_BLOCKS      : number of carry-select blocks at the default block width
//   num_blocks()    : block count for an arbitrary legal block width
// ---------------------------------------------------------------------------
package csa_pkg;

  localparam int WIDTH           = 16;
  localparam int BLOCK_W_DEFAULT = 4;

  function automatic int num_blocks(input int block_w);
    return WIDTH / block_w;
  endfunction

  localparam int NUM_BLOCKS = num_blocks(BLOCK_W_DEFAULT);

endpackage : csa_pkg

// File: rtl/rca_block.sv
// ---------------------------------------------------------------------------
// rca_block
// BLOCK_W-bit ripple-carry adder built from per-bit full-adder equations.
// Ports:
//   a, b : BLOCK_W-bit addends
//   cin  : carry into bit 0
//   s    : BLOCK_W-bit sum
//   cout : carry out of the top bit
// ---------------------------------------------------------------------------
module rca_block #(
  parameter int BLOCK_W = 4
) (
  input  logic [BLOCK_W-1:0] a,
  input  logic [BLOCK_W-1:0] b,
  input  logic               cin,
  output logic [BLOCK_W-1:0] s,
  output logic               cout
);

  // w_c[i] is the carry into bit i; w_c[BLOCK_W] leaves the block.
  logic [BLOCK_W:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < BLOCK_W; i++) begin : g_fa
    logic w_p;
    assign w_p        = a[i] ^ b[i];
    assign s[i]       = w_p ^ w_c[i];
    assign w_c[i + 1] = (a[i] & b[i]) | (w_p & w_c[i]);
  end

  assign cout = w_c[BLOCK_W];

endmodule : rca_block

// File: rtl/csa_16bit.sv
// ---------------------------------------------------------------------------
// csa_16bit
// 16-bit unsigned carry-select adder with a registered copy of the result.
// The lowest block is a single ripple block with carry-in 0; every higher
// block computes both carry-in hypotheses and the real carry from below
// selects between them.
// Ports:
//   clk     : clock
//   rst     : asynchronous active-high reset (clears registered outputs only)
//   A, B    : 16-bit unsigned addends
//   S       : combinational sum, A+B mod 2^16
//   C_out   : combinational carry out of bit 15
//   S_q     : S registered on every rising clk edge
//   C_out_q : C_out registered on every rising clk edge
// Optional (macro CSA_16BIT_OVF_EN):
//   V       : combinational two's-complement overflow
//   V_q     : V registered, reset to 0
// ---------------------------------------------------------------------------
module csa_16bit
  import csa_pkg::*;
#(
  parameter int BLOCK_W = csa_pkg::BLOCK_W_DEFAULT  // legal: 2, 4, 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic [WIDTH-1:0]  S,
  output logic              C_out,
  output logic [WIDTH-1:0]  S_q,
  output logic              C_out_q
`ifdef CSA_16BIT_OVF_EN
  ,
  output logic              V,
  output logic              V_q
`endif
);

  localparam int NUM_BLK = num_blocks(BLOCK_W);

  // w_carry[k] is the resolved carry into block k.
  logic [NUM_BLK:0] w_carry;

  assign w_carry[0] = 1'b0;

  for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
    if (k == 0) begin : g_base
      rca_block #(.BLOCK_W(BLOCK_W)) u_rca (
        .a    (A[BLOCK_W-1:0]),
        .b    (B[BLOCK_W-1:0]),
        .cin  (1'b0),
        .s    (S[BLOCK_W-1:0]),
        .cout (w_carry[1])
      );
    end else begin : g_sel
      logic [BLOCK_W-1:0] w_s0;
      logic [BLOCK_W-1:0] w_s1;
      logic               w_c0;
      logic               w_c1;

      rca_block #(.BLOCK_W(BLOCK_W)) u_rca0 (
        .a    (A[k*BLOCK_W +: BLOCK_W]),
        .b    (B[k*BLOCK_W +: BLOCK_W]),
        .cin  (1'b0),
        .s    (w_s0),
        .cout (w_c0)
      );

      rca_block #(.BLOCK_W(BLOCK_W)) u_rca1 (
        .a    (A[k*BLOCK_W +: BLOCK_W]),
        .b    (B[k*BLOCK_W +: BLOCK_W]),
        .cin  (1'b1),
        .s    (w_s1),
        .cout (w_c1)
      );

      // Both select inputs are always driven from known rca outputs, so a
      // known carry never propagates X through the mux tree.
      assign S[k*BLOCK_W +: BLOCK_W] = w_carry[k] ? w_s1 : w_s0;
      assign w_carry[k + 1]          = w_carry[k] ? w_c1 : w_c0;
    end
  end

  assign C_out = w_carry[NUM_BLK];

  logic [WIDTH-1:0] r_s_q;
  logic             r_c_out_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_q     <= '0;
      r_c_out_q <= 1'b0;
    end else begin
      r_s_q     <= S;
      r_c_out_q <= C_out;
    end
  end

  assign S_q     = r_s_q;
  assign C_out_q = r_c_out_q;

`ifdef CSA_16BIT_OVF_EN
  // The carry into bit 15 is not exposed by the select tree; it is recovered
  // from the top-bit sum equation: s15 = a15 ^ b15 ^ c15.
  logic w_c_into_msb;
  logic r_v_q;

  assign w_c_into_msb = A[WIDTH-1] ^ B[WIDTH-1] ^ S[WIDTH-1];
  assign V            = w_c_into_msb ^ C_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v_q <= 1'b0;
    end else begin
      r_v_q <= V;
    end
  end

  assign V_q = r_v_q;
`endif

endmodule : csa_16bit

// File: tb/tb_csa_16bit.sv
// ---------------------------------------------------------------------------
// tb_csa_16bit
// Self-checking bench for csa_16bit: directed vectors with fixed expected
// values, reset behaviour, and random pairs against a 17-bit arithmetic model.
// ---------------------------------------------------------------------------
module tb_csa_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] S;
  logic        C_out;
  logic [15:0] S_q;
  logic        C_out_q;
`ifdef CSA_16BIT_OVF_EN
  logic        V;
  logic        V_q;
`endif

  int checks = 0;
  int errors = 0;

  csa_16bit dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .S       (S),
    .C_out   (C_out),
    .S_q     (S_q),
    .C_out_q (C_out_q)
`ifdef CSA_16BIT_OVF_EN
    ,
    .V       (V),
    .V_q     (V_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Golden 17-bit unsigned sum.
  function automatic logic [16:0] model_sum(input logic [15:0] a, input logic [15:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Signed overflow: true result outside the 16-bit two's-complement range.
  function automatic logic model_ovf(input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    int r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sa + sb;
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a pair mid-cycle, check the combinational result, then check the
  // registered copy one edge later.
  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [16:0] exp);
    @(negedge clk);
    A = a;
    B = b;
    #1;
    check({tag, "_comb"}, {C_out, S}, exp);
    @(posedge clk);
    #1;
    check({tag, "_reg"}, {C_out_q, S_q}, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;

    rst = 1'b0;
    A   = 16'h0000;
    B   = 16'h0000;
    #1;
    rst = 1'b1;
    #1;
    // Async reset: registers clear before any clock edge.
    check("reset_s_q", {1'b0, S_q}, 17'h00000);
    check("reset_c_out_q", {16'h0, C_out_q}, 17'h00000);
`ifdef CSA_16BIT_OVF_EN
    check("reset_v_q", {16'h0, V_q}, 17'h00000);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-derived expected {C_out,S}.
    apply("zero",      16'h0000, 16'h0000, 17'h0_0000);
    apply("basic",     16'h1234, 16'h2345, 17'h0_3579);
    apply("blk0_cross",16'h000F, 16'h0001, 17'h0_0010);
    apply("all_cross", 16'h0FFF, 16'h0001, 17'h0_1000);
    apply("wrap_one",  16'hFFFF, 16'h0001, 17'h1_0000);
    apply("wrap_max",  16'hFFFF, 16'hFFFF, 17'h1_FFFE);

    // Mid-cycle reset with FFFF+FFFF still on the inputs.
    #2;
    rst = 1'b1;
    #1;
    check("midrst_s_q", {C_out_q, S_q}, 17'h0_0000);
    check("midrst_s",   {C_out, S},     17'h1_FFFE);
    @(posedge clk);
    #1;
    check("rst_hold_s_q", {C_out_q, S_q}, 17'h0_0000);
    @(negedge clk);
    rst = 1'b0;
    A   = 16'h8001;
    B   = 16'h8002;
    @(posedge clk);
    #1;
    // First edge after release loads the current sum.
    check("post_rst_load", {C_out_q, S_q}, 17'h1_0003);

`ifdef CSA_16BIT_OVF_EN
    @(negedge clk);
    A = 16'h7FFF;
    B = 16'h0001;
    #1;
    check("ovf_pos", {16'h0, V}, 17'h00001);
    @(posedge clk);
    #1;
    check("ovf_pos_q", {16'h0, V_q}, 17'h00001);
    @(negedge clk);
    A = 16'h8000;
    B = 16'hFFFF;
    #1;
    check("ovf_neg", {16'h0, V}, 17'h00001);
    @(negedge clk);
    A = 16'h7FFF;
    B = 16'hFFFF;
    #1;
    check("ovf_none", {16'h0, V}, 17'h00000);
`endif

    // Random pairs against the arithmetic model.
    for (int n = 0; n < 10000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      apply("rand", ra, rb, model_sum(ra, rb));
`ifdef CSA_16BIT_OVF_EN
      check("rand_ovf_q", {16'h0, V_q}, {16'h0, model_ovf(ra, rb)});
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_csa_16bit
